// File: rtl/mem_addr_trans_if.sv
// Request/response bundle between the EX stage, the translation stage and MEM.
// The master issues VAs and consumes results; the slave is the translation stage.
interface mem_addr_trans_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_va;
   logic [1:0]  req_op;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_pa;
   logic [1:0]  rsp_mat;
   logic        rsp_exc;
   logic [5:0]  rsp_ecode;
   logic [31:0] rsp_badv;
   logic        rsp_tlb_hit;
   logic [3:0]  rsp_tlb_idx;

   modport master (
      output req_valid, req_va, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_pa, rsp_mat, rsp_exc, rsp_ecode,
             rsp_badv, rsp_tlb_hit, rsp_tlb_idx
   );

   modport slave (
      input  req_valid, req_va, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_pa, rsp_mat, rsp_exc, rsp_ecode,
             rsp_badv, rsp_tlb_hit, rsp_tlb_idx
   );
endinterface

// File: rtl/mem_addr_trans.sv
// Data-path VA->PA translation (DA / DMW0 / DMW1 / TLB) into a one-entry output register.
// Define DMW_EN to decode the DMW0/DMW1 windows; without it every PG-mode access uses the TLB.
module mem_addr_trans (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   mem_addr_trans_if.slave bus,
   input  logic            csr_crmd_da,
   input  logic            csr_crmd_pg,
   input  logic [1:0]      csr_crmd_plv,
   input  logic [1:0]      csr_crmd_datm,
   input  logic [31:0]     csr_dmw0,
   input  logic [31:0]     csr_dmw1,
   input  logic [9:0]      csr_asid,
   output logic [18:0]     tlb_vppn,
   output logic            tlb_va_bit12,
   output logic [9:0]      tlb_asid,
   input  logic            tlb_found,
   input  logic [3:0]      tlb_index,
   input  logic [19:0]     tlb_ppn,
   input  logic [5:0]      tlb_ps,
   input  logic [1:0]      tlb_plv,
   input  logic [1:0]      tlb_mat,
   input  logic            tlb_d,
   input  logic            tlb_v
);
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

   typedef struct packed {
      logic [31:0] pa;
      logic [1:0]  mat;
      logic        exc;
      logic [5:0]  ecode;
      logic [31:0] badv;
      logic        hit;
      logic [3:0]  idx;
   } entry_t;

   localparam logic [5:0] ECODE_PIL  = 6'h01;
   localparam logic [5:0] ECODE_PIS  = 6'h02;
   localparam logic [5:0] ECODE_PIF  = 6'h03;
   localparam logic [5:0] ECODE_PME  = 6'h04;
   localparam logic [5:0] ECODE_PPI  = 6'h07;
   localparam logic [5:0] ECODE_TLBR = 6'h3F;

   state_e     state_q, state_d;
   entry_t     entry_q, entry_d;
   entry_t     xlat;
   logic [5:0] tlb_ecode;
   logic       accept;
   logic       take;
   logic       is_store;
   logic       is_fetch;

   // PG is implied whenever DA is clear; unused DMW fields are only decoded when enabled.
   logic unused_csr;
   assign unused_csr = ^{csr_crmd_pg, csr_dmw0, csr_dmw1};

`ifdef DMW_EN
   function automatic logic dmw_hit(input logic [31:0] dmw, input logic [2:0] vseg,
                                    input logic [1:0] plv);
      return (dmw[31:29] == vseg) &&
             (((plv == 2'd0) && dmw[0]) || ((plv == 2'd3) && dmw[3]));
   endfunction
`endif

   assign tlb_vppn     = bus.req_va[31:13];
   assign tlb_va_bit12 = bus.req_va[12];
   assign tlb_asid     = csr_asid;

   assign is_store = (bus.req_op == 2'd2);
   assign is_fetch = (bus.req_op == 2'd0);
   assign accept   = bus.req_valid & bus.req_ready;
   assign take     = bus.rsp_valid & bus.rsp_ready;

   always_comb begin
      // NOTE: every variable written here gets a default first, so no latch can be inferred.
      xlat      = '0;
      xlat.badv = bus.req_va;
      tlb_ecode = '0;
      if (csr_crmd_da) begin
         xlat.pa  = bus.req_va;
         xlat.mat = csr_crmd_datm;
      end
`ifdef DMW_EN
      else if (dmw_hit(csr_dmw0, bus.req_va[31:29], csr_crmd_plv)) begin
         xlat.pa  = {csr_dmw0[27:25], bus.req_va[28:0]};
         xlat.mat = csr_dmw0[5:4];
      end
      else if (dmw_hit(csr_dmw1, bus.req_va[31:29], csr_crmd_plv)) begin
         xlat.pa  = {csr_dmw1[27:25], bus.req_va[28:0]};
         xlat.mat = csr_dmw1[5:4];
      end
`endif
      else if (!tlb_found) begin
         xlat.exc   = 1'b1;
         xlat.ecode = ECODE_TLBR;
      end
      else begin
         xlat.hit = 1'b1;
         xlat.idx = tlb_index;
         if (!tlb_v)
            tlb_ecode = is_store ? ECODE_PIS : (is_fetch ? ECODE_PIF : ECODE_PIL);
         else if (csr_crmd_plv > tlb_plv)
            tlb_ecode = ECODE_PPI;
         else if (is_store && !tlb_d)
            tlb_ecode = ECODE_PME;

         // A faulting access reports no address or memory type.
         if (tlb_ecode != 6'd0) begin
            xlat.exc   = 1'b1;
            xlat.ecode = tlb_ecode;
         end
         else begin
            xlat.pa  = (tlb_ps == 6'd22) ? {tlb_ppn[19:10], bus.req_va[21:0]}
                                         : {tlb_ppn, bus.req_va[11:0]};
            xlat.mat = tlb_mat;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (accept) state_d = FULL;
         FULL:    if (take && !accept) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
      if (flush) state_d = EMPTY;
   end

   always_comb begin
      bus.rsp_valid = (state_q == FULL);
      bus.req_ready = (state_q == EMPTY) | bus.rsp_ready;
   end

   assign entry_d = (accept && !flush) ? xlat : entry_q;

   // NOTE: the async reset clears every output field so MEM never sees stale data after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
         entry_q <= '0;
      end
      else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         state_q <= state_d;
         entry_q <= entry_d;
      end
   end

   assign bus.rsp_pa      = entry_q.pa;
   assign bus.rsp_mat     = entry_q.mat;
   assign bus.rsp_exc     = entry_q.exc;
   assign bus.rsp_ecode   = entry_q.ecode;
   assign bus.rsp_badv    = entry_q.badv;
   assign bus.rsp_tlb_hit = entry_q.hit;
   assign bus.rsp_tlb_idx = entry_q.idx;
endmodule

// File: tb/tb_mem_addr_trans.sv
// Self-checking bench for mem_addr_trans: directed cases with literal expectations plus
// randomized traffic compared every cycle against a behavioural translation/stage model.
module tb_mem_addr_trans;
   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        csr_crmd_da, csr_crmd_pg;
   logic [1:0]  csr_crmd_plv, csr_crmd_datm;
   logic [31:0] csr_dmw0, csr_dmw1;
   logic [9:0]  csr_asid;
   logic [18:0] tlb_vppn;
   logic        tlb_va_bit12;
   logic [9:0]  tlb_asid;
   logic        tlb_found, tlb_d, tlb_v;
   logic [3:0]  tlb_index;
   logic [19:0] tlb_ppn;
   logic [5:0]  tlb_ps;
   logic [1:0]  tlb_plv, tlb_mat;

   mem_addr_trans_if bus();

   mem_addr_trans dut (
      .clk(clk), .reset(reset), .flush(flush), .bus(bus),
      .csr_crmd_da(csr_crmd_da), .csr_crmd_pg(csr_crmd_pg),
      .csr_crmd_plv(csr_crmd_plv), .csr_crmd_datm(csr_crmd_datm),
      .csr_dmw0(csr_dmw0), .csr_dmw1(csr_dmw1), .csr_asid(csr_asid),
      .tlb_vppn(tlb_vppn), .tlb_va_bit12(tlb_va_bit12), .tlb_asid(tlb_asid),
      .tlb_found(tlb_found), .tlb_index(tlb_index), .tlb_ppn(tlb_ppn), .tlb_ps(tlb_ps),
      .tlb_plv(tlb_plv), .tlb_mat(tlb_mat), .tlb_d(tlb_d), .tlb_v(tlb_v)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pa;
      logic [1:0]  mat;
      logic        exc;
      logic [5:0]  ecode;
      logic [31:0] badv;
      logic        hit;
      logic [3:0]  idx;
   } exp_t;

   logic m_valid = 1'b0;
   exp_t m_entry = '0;
   int   n_vec   = 0;
   int   n_miss  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Translation result computed directly from the mode/window/TLB rules.
   function automatic exp_t translate();
      exp_t        e;
      logic [5:0]  code;
      logic [31:0] va;
      logic [31:0] dmw;
      e    = '0;
      code = 6'd0;
      va   = bus.req_va;
      e.badv = va;
      if (csr_crmd_da) begin
         e.pa  = va;
         e.mat = csr_crmd_datm;
         return e;
      end
`ifdef DMW_EN
      for (int w = 0; w < 2; w++) begin
         dmw = (w == 0) ? csr_dmw0 : csr_dmw1;
         if (va[31:29] == dmw[31:29] &&
             ((csr_crmd_plv == 2'd0 && dmw[0]) || (csr_crmd_plv == 2'd3 && dmw[3]))) begin
            e.pa  = (32'(dmw[27:25]) << 29) | (va & 32'h1FFF_FFFF);
            e.mat = dmw[5:4];
            return e;
         end
      end
`else
      dmw = 32'd0;
`endif
      if (!tlb_found) begin
         e.exc   = 1'b1;
         e.ecode = 6'h3F;
         return e;
      end
      e.hit = 1'b1;
      e.idx = tlb_index;
      if (!tlb_v)                                     code = (bus.req_op == 2) ? 6'd2 : (bus.req_op == 0) ? 6'd3 : 6'd1;
      else if (csr_crmd_plv > tlb_plv)                code = 6'd7;
      else if (bus.req_op == 2 && !tlb_d)             code = 6'd4;
      if (code != 0) begin
         e.exc   = 1'b1;
         e.ecode = code;
         return e;
      end
      if (tlb_ps == 6'd22) e.pa = ((32'(tlb_ppn) << 12) & 32'hFFC0_0000) | (va & 32'h003F_FFFF);
      else                 e.pa = (32'(tlb_ppn) << 12) | (va & 32'h0000_0FFF);
      e.mat = tlb_mat;
      return e;
   endfunction

   task automatic compare_all();
      check("req_ready", 32'(bus.req_ready), 32'(!m_valid | bus.rsp_ready));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
      if (m_valid) begin
         check("rsp_pa",      bus.rsp_pa,               m_entry.pa);
         check("rsp_mat",     32'(bus.rsp_mat),         32'(m_entry.mat));
         check("rsp_exc",     32'(bus.rsp_exc),         32'(m_entry.exc));
         check("rsp_ecode",   32'(bus.rsp_ecode),       32'(m_entry.ecode));
         check("rsp_badv",    bus.rsp_badv,             m_entry.badv);
         check("rsp_tlb_hit", 32'(bus.rsp_tlb_hit),     32'(m_entry.hit));
         check("rsp_tlb_idx", 32'(bus.rsp_tlb_idx),     32'(m_entry.idx));
      end
      check("tlb_vppn",  32'(tlb_vppn),     32'(bus.req_va >> 13));
      check("tlb_bit12", 32'(tlb_va_bit12), 32'(bus.req_va[12]));
      check("tlb_asid",  32'(tlb_asid),     32'(csr_asid));
   endtask

   // One clock: predict the stage from the driven inputs, then compare on the falling edge.
   task automatic tick();
      logic rdy;
      logic n_valid;
      exp_t n_entry;
      rdy     = !m_valid | bus.rsp_ready;
      n_valid = m_valid;
      n_entry = m_entry;
      if (flush) n_valid = 1'b0;
      else if (bus.req_valid && rdy) begin
         n_valid = 1'b1;
         n_entry = translate();
      end
      else if (m_valid && bus.rsp_ready) n_valid = 1'b0;
      @(posedge clk);
      m_valid = n_valid;
      m_entry = n_entry;
      @(negedge clk);
      compare_all();
   endtask

   task automatic send(input logic [31:0] va, input logic [1:0] op);
      bus.req_valid = 1'b1;
      bus.req_va    = va;
      bus.req_op    = op;
      bus.rsp_ready = 1'b1;
      tick();
      bus.req_valid = 1'b0;
   endtask

   task automatic set_tlb(input logic found, input logic v, input logic d, input logic [1:0] plv,
                          input logic [19:0] ppn, input logic [5:0] ps, input logic [1:0] mat,
                          input logic [3:0] idx);
      tlb_found = found; tlb_v = v; tlb_d = d; tlb_plv = plv;
      tlb_ppn = ppn; tlb_ps = ps; tlb_mat = mat; tlb_index = idx;
   endtask

   task automatic expect_rsp(input string tag, input logic [31:0] pa, input logic [1:0] mat,
                             input logic exc, input logic [5:0] ecode, input logic [31:0] badv,
                             input logic hit, input logic [3:0] idx);
      check({tag, ".valid"}, 32'(bus.rsp_valid),   32'd1);
      check({tag, ".pa"},    bus.rsp_pa,           pa);
      check({tag, ".mat"},   32'(bus.rsp_mat),     32'(mat));
      check({tag, ".exc"},   32'(bus.rsp_exc),     32'(exc));
      check({tag, ".ecode"}, 32'(bus.rsp_ecode),   32'(ecode));
      check({tag, ".badv"},  bus.rsp_badv,         badv);
      check({tag, ".hit"},   32'(bus.rsp_tlb_hit), 32'(hit));
      check({tag, ".idx"},   32'(bus.rsp_tlb_idx), 32'(idx));
   endtask

   task automatic expect_cleared(input string tag);
      check({tag, ".valid"}, 32'(bus.rsp_valid),   32'd0);
      check({tag, ".pa"},    bus.rsp_pa,           32'd0);
      check({tag, ".mat"},   32'(bus.rsp_mat),     32'd0);
      check({tag, ".exc"},   32'(bus.rsp_exc),     32'd0);
      check({tag, ".ecode"}, 32'(bus.rsp_ecode),   32'd0);
      check({tag, ".badv"},  bus.rsp_badv,         32'd0);
      check({tag, ".hit"},   32'(bus.rsp_tlb_hit), 32'd0);
      check({tag, ".idx"},   32'(bus.rsp_tlb_idx), 32'd0);
      check({tag, ".ready"}, 32'(bus.req_ready),   32'd1);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0;
      bus.req_valid = 1'b0; bus.req_va = 32'd0; bus.req_op = 2'd1; bus.rsp_ready = 1'b0;
      csr_crmd_da = 1'b1; csr_crmd_pg = 1'b0; csr_crmd_plv = 2'd0; csr_crmd_datm = 2'd0;
      csr_dmw0 = 32'd0; csr_dmw1 = 32'd0; csr_asid = 10'h155;
      set_tlb(1'b0, 1'b0, 1'b0, 2'd0, 20'd0, 6'd12, 2'd0, 4'd0);
      repeat (2) @(negedge clk);
      expect_cleared("reset");
      reset = 1'b0;

      // DA mode
      csr_crmd_datm = 2'd1;
      send(32'h1C00_0100, 2'd1);
      expect_rsp("da", 32'h1C00_0100, 2'd1, 1'b0, 6'd0, 32'h1C00_0100, 1'b0, 4'd0);

      // DMW0 window at PLV0, then the same VA at PLV3 falls through to a TLB miss
      csr_crmd_da = 1'b0; csr_crmd_pg = 1'b1; csr_dmw0 = 32'hA000_0011;
      send(32'hA000_1234, 2'd1);
`ifdef DMW_EN
      expect_rsp("dmw0", 32'h0000_1234, 2'd1, 1'b0, 6'd0, 32'hA000_1234, 1'b0, 4'd0);
`else
      expect_rsp("dmw0", 32'h0, 2'd0, 1'b1, 6'h3F, 32'hA000_1234, 1'b0, 4'd0);
`endif
      csr_crmd_plv = 2'd3;
      send(32'hA000_1234, 2'd1);
      expect_rsp("dmw_plv3", 32'h0, 2'd0, 1'b1, 6'h3F, 32'hA000_1234, 1'b0, 4'd0);
      csr_dmw0 = 32'd0; csr_crmd_plv = 2'd0;

      // TLB translations
      set_tlb(1'b1, 1'b1, 1'b1, 2'd3, 20'h12345, 6'd12, 2'd1, 4'd5);
      send(32'h0040_2ABC, 2'd1);
      expect_rsp("tlb4k", 32'h1234_5ABC, 2'd1, 1'b0, 6'd0, 32'h0040_2ABC, 1'b1, 4'd5);
      set_tlb(1'b1, 1'b1, 1'b1, 2'd3, 20'h00C00, 6'd22, 2'd2, 4'd9);
      send(32'h0065_4321, 2'd1);
      expect_rsp("tlb4m", 32'h00E5_4321, 2'd2, 1'b0, 6'd0, 32'h0065_4321, 1'b1, 4'd9);

      // TLB exceptions
      set_tlb(1'b0, 1'b1, 1'b1, 2'd3, 20'h12345, 6'd12, 2'd1, 4'd3);
      send(32'h0040_1000, 2'd1);
      expect_rsp("tlbr", 32'h0, 2'd0, 1'b1, 6'h3F, 32'h0040_1000, 1'b0, 4'd0);
      set_tlb(1'b1, 1'b0, 1'b1, 2'd3, 20'h12345, 6'd12, 2'd1, 4'd3);
      send(32'h0040_2000, 2'd2);
      expect_rsp("pis", 32'h0, 2'd0, 1'b1, 6'h02, 32'h0040_2000, 1'b1, 4'd3);
      csr_crmd_plv = 2'd3;
      set_tlb(1'b1, 1'b1, 1'b1, 2'd0, 20'h12345, 6'd12, 2'd1, 4'd4);
      send(32'h0040_3000, 2'd1);
      expect_rsp("ppi", 32'h0, 2'd0, 1'b1, 6'h07, 32'h0040_3000, 1'b1, 4'd4);
      csr_crmd_plv = 2'd0;
      set_tlb(1'b1, 1'b1, 1'b0, 2'd3, 20'h12345, 6'd12, 2'd1, 4'd6);
      send(32'h0040_4000, 2'd2);
      expect_rsp("pme", 32'h0, 2'd0, 1'b1, 6'h04, 32'h0040_4000, 1'b1, 4'd6);

      // Back-pressure: first entry held for 3 cycles, second accepted once MEM takes
      set_tlb(1'b1, 1'b1, 1'b1, 2'd3, 20'h11111, 6'd12, 2'd1, 4'd1);
      bus.rsp_ready = 1'b1; tick();
      bus.req_valid = 1'b1; bus.req_va = 32'h0000_1AAA; bus.rsp_ready = 1'b0; tick();
      bus.req_va = 32'h0000_2BBB;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp.ready", 32'(bus.req_ready), 32'd0);
         check("bp.badv",  bus.rsp_badv,       32'h0000_1AAA);
      end
      bus.rsp_ready = 1'b1; tick();
      check("bp.next", bus.rsp_badv, 32'h0000_2BBB);
      bus.req_valid = 1'b0; tick();
      check("bp.drain", 32'(bus.rsp_valid), 32'd0);

      // Flush with a simultaneous accept drops the request
      bus.req_valid = 1'b1; bus.req_va = 32'h0000_3CCC; flush = 1'b1; tick();
      check("flush.valid", 32'(bus.rsp_valid), 32'd0);
      flush = 1'b0; bus.req_valid = 1'b0;

      // Reset while FULL clears the entry immediately
      send(32'h0000_4DDD, 2'd1);
      check("pre_reset.valid", 32'(bus.rsp_valid), 32'd1);
      reset = 1'b1;
      #1;
      expect_cleared("reset_full");
      m_valid = 1'b0;
      m_entry = '0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         bus.req_valid = ($urandom_range(9) < 7);
         bus.rsp_ready = ($urandom_range(9) < 7);
         flush         = ($urandom_range(15) == 0);
         bus.req_va    = $urandom;
         bus.req_op    = 2'($urandom_range(3));
         csr_crmd_da   = ($urandom_range(3) == 0);
         csr_crmd_pg   = !csr_crmd_da;
         csr_crmd_plv  = 2'($urandom_range(3));
         csr_crmd_datm = 2'($urandom_range(3));
         csr_asid      = 10'($urandom);
         csr_dmw0      = $urandom;
         csr_dmw1      = $urandom;
         if ($urandom_range(1) == 1) csr_dmw0[31:29] = bus.req_va[31:29];
         if ($urandom_range(1) == 1) csr_dmw1[31:29] = bus.req_va[31:29];
         set_tlb(($urandom_range(4) != 0), ($urandom_range(4) != 0), 1'($urandom),
                 2'($urandom_range(3)), 20'($urandom),
                 ($urandom_range(1) == 1) ? 6'd22 : 6'd12, 2'($urandom_range(3)),
                 4'($urandom_range(15)));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
